// File: rtl/note_pkg.sv
// Shared definitions for the song sequencer: field widths, ROM word layout,
// sequencer state encoding and small helpers for packing/unpacking ROM words.
package note_pkg;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int ROM_W    = NOTE_W + DUR_W;
    localparam int NOTE_LSB = DUR_W;
    localparam int DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] REST_NOTE    = '0;
    localparam logic [DUR_W-1:0]  END_DURATION = '0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ROM = 3'd2,
        LOAD     = 3'd3,
        ARM      = 3'd4,
        PLAYING  = 3'd5,
        DONE     = 3'd6
    } reader_state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [ROM_W-1:0] word);
        return word[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [ROM_W-1:0] word);
        return word[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic [ROM_W-1:0] make_word(input logic [NOTE_W-1:0] note,
                                                   input logic [DUR_W-1:0]  dur);
        return {note, dur};
    endfunction

endpackage

// File: rtl/song_rom.sv
// Registered song ROM: one 12-bit {note, duration} word per entry, read data
// appears one cycle after the address. A zero duration marks the end of a song.
module song_rom
    import note_pkg::*;
#(
    parameter  int SONG_BITS      = 2,
    parameter  int NOTE_ADDR_BITS = 5,
    localparam int ROM_ADDR_W     = SONG_BITS + NOTE_ADDR_BITS
) (
    input  logic                  clk,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]      data
);

    logic [SONG_BITS-1:0]      song_sel;
    logic [NOTE_ADDR_BITS-1:0] entry;
    logic [ROM_W-1:0]          word;

    assign song_sel = addr[ROM_ADDR_W-1 -: SONG_BITS];
    assign entry    = addr[NOTE_ADDR_BITS-1:0];

    // Anything not listed reads as a rest with the end-of-song duration.
    always_comb begin
        word = make_word(REST_NOTE, END_DURATION);
        case (int'(song_sel))
            0: begin
                case (int'(entry))
                    0:       word = make_word(6'd5, 6'd3);
                    1:       word = make_word(6'd9, 6'd6);
                    default: word = make_word(REST_NOTE, END_DURATION);
                endcase
            end
            1: begin
                case (int'(entry))
                    0:       word = make_word(6'd12, 6'd4);
                    1:       word = make_word(6'd20, 6'd2);
                    2:       word = make_word(REST_NOTE, 6'd3);
                    default: word = make_word(REST_NOTE, END_DURATION);
                endcase
            end
            2: begin
                case (int'(entry))
                    0:       word = make_word(6'd30, 6'd2);
                    1:       word = make_word(6'd31, 6'd2);
                    2:       word = make_word(6'd32, 6'd4);
                    default: word = make_word(REST_NOTE, END_DURATION);
                endcase
            end
            3: begin
                // Full-length song with no end marker: exercises index wrap.
                word = make_word(NOTE_W'(entry) + NOTE_W'(1),
                                 DUR_W'(entry[1:0]) + DUR_W'(1));
            end
            default: word = make_word(REST_NOTE, END_DURATION);
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/song_reader.sv
// Song sequencer feeding note_player: walks the ROM entry by entry and strobes
// {note, duration} out. Build option SONG_READER_REPEAT_EN loops songs forever.
module song_reader
    import note_pkg::*;
#(
    parameter  int SONG_BITS      = 2,
    parameter  int NOTE_ADDR_BITS = 5,
    localparam int ROM_ADDR_W     = SONG_BITS + NOTE_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic [SONG_BITS-1:0]  song,
    input  logic                  done_with_note,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]      rom_data,
    output logic [NOTE_W-1:0]     note_to_load,
    output logic [DUR_W-1:0]      duration_to_load,
    output logic                  load_new_note,
    output logic                  song_done
);

    reader_state_t             state;
    reader_state_t             next_state;
    logic [NOTE_ADDR_BITS-1:0] entry_index;
    logic [NOTE_ADDR_BITS-1:0] index_next;
    logic [SONG_BITS-1:0]      song_latched;
    logic [SONG_BITS-1:0]      latched_next;
    logic                      end_flag;
    logic                      song_changed;
    logic                      capture;
    logic                      strobe_next;
    logic                      done_next;
    logic                      addr_update;

    assign song_changed = (song != song_latched);

    always_comb begin
        next_state   = state;
        index_next   = entry_index;
        latched_next = song_latched;
        capture      = 1'b0;
        strobe_next  = 1'b0;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                index_next   = '0;
                latched_next = song;
                if (play) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = WAIT_ROM;
            end
            WAIT_ROM: begin
                // Decide the LOAD-cycle strobe/pulse now so both leave a flop.
                next_state  = LOAD;
                capture     = (word_dur(rom_data) != END_DURATION);
                strobe_next = capture;
                done_next   = !capture;
            end
            LOAD: begin
                if (end_flag) begin
`ifdef SONG_READER_REPEAT_EN
                    index_next = '0;
                    next_state = FETCH;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = ARM;
                end
            end
            ARM: begin
                next_state = PLAYING;
            end
            PLAYING: begin
                if (done_with_note && play) begin
                    index_next = entry_index + NOTE_ADDR_BITS'(1);
                    if (entry_index == '1) begin
                        done_next = 1'b1;
`ifdef SONG_READER_REPEAT_EN
                        next_state = FETCH;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = FETCH;
                    end
                end
            end
            DONE: begin
                if (!play || song_changed) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A new song selection silently abandons whatever is in progress.
        if (state != IDLE && state != DONE && song_changed) begin
            next_state  = IDLE;
            index_next  = entry_index;
            capture     = 1'b0;
            strobe_next = 1'b0;
            done_next   = 1'b0;
        end
    end

    assign addr_update = (state == IDLE) || (next_state == FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            entry_index      <= '0;
            song_latched     <= '0;
            rom_addr         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
            end_flag         <= 1'b0;
        end else begin
            state         <= next_state;
            entry_index   <= index_next;
            song_latched  <= latched_next;
            load_new_note <= strobe_next;
            song_done     <= done_next;
            if (state == WAIT_ROM) begin
                end_flag <= (word_dur(rom_data) == END_DURATION);
            end
            // Outputs keep the last real note; end markers never overwrite them.
            if (capture) begin
                note_to_load     <= word_note(rom_data);
                duration_to_load <= word_dur(rom_data);
            end
            if (addr_update) begin
                rom_addr <= {latched_next, index_next};
            end
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with song_rom as the data source; expected
// notes are queued per song and checked on every load_new_note strobe.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        done_with_note;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        song_done;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    int          strobe_count = 0;
    int          done_count = 0;
    int          cycle = 0;
    int          last_strobe = -1000;
    int          min_gap = 1000;
    bit          window_en = 1'b0;
    logic [1:0]  window_song = 2'd0;
    bit          addr_bad = 1'b0;

    always #5 clk = ~clk;

    song_reader #(.SONG_BITS(2), .NOTE_ADDR_BITS(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .done_with_note   (done_with_note),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done)
    );

    song_rom #(.SONG_BITS(2), .NOTE_ADDR_BITS(5)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] mk(input int n, input int d);
        return {n[5:0], d[5:0]};
    endfunction

    task automatic pushSong(input int which);
        case (which)
            0: begin
                exp_q.push_back(mk(5, 3));
                exp_q.push_back(mk(9, 6));
            end
            1: begin
                exp_q.push_back(mk(12, 4));
                exp_q.push_back(mk(20, 2));
                exp_q.push_back(mk(0, 3));
            end
            2: begin
                exp_q.push_back(mk(30, 2));
                exp_q.push_back(mk(31, 2));
                exp_q.push_back(mk(32, 4));
            end
            default: begin
                for (int i = 0; i < 32; i++) exp_q.push_back(mk(i + 1, (i % 4) + 1));
            end
        endcase
    endtask

    // Scoreboard side: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [11:0] exp_word;
        cycle++;
        if (load_new_note === 1'b1) begin
            strobe_count++;
            if (cycle - last_strobe < min_gap) min_gap = cycle - last_strobe;
            last_strobe = cycle;
            checkOutput("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                checkOutput("note_to_load", 32'(note_to_load), 32'(exp_word[11:6]));
                checkOutput("duration_to_load", 32'(duration_to_load), 32'(exp_word[5:0]));
            end
        end
        if (song_done === 1'b1) done_count++;
        if (window_en && rom_addr[6:5] !== window_song) addr_bad = 1'b1;
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic [1:0] s,
                                 input logic d);
        reset          = r;
        play           = p;
        song           = s;
        done_with_note = d;
    endtask

    // Counts negedges until the chosen output is seen, bounded by budget.
    task automatic waitEvent(input bit want_done, input int budget, input string tag,
                             output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            seen = want_done ? (song_done === 1'b1) : (load_new_note === 1'b1);
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int w;
        int s0;
        int d0;

        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        stepCycles(3);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset_note", 32'(note_to_load), 32'd0);
        checkOutput("reset_duration", 32'(duration_to_load), 32'd0);
        checkOutput("reset_load", 32'(load_new_note), 32'd0);
        checkOutput("reset_song_done", 32'(song_done), 32'd0);

`ifndef SONG_READER_REPEAT_EN
        // Song 1, done_with_note pulsed once per note.
        $display("[TB] song 1 with per-note done pulses");
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b0);
        stepCycles(2);
        pushSong(1);
        s0   = strobe_count;
        d0   = done_count;
        play = 1'b1;
        waitEvent(1'b0, 20, "t1_first_strobe", w);
        checkOutput("t1_first_latency", 32'(w), 32'd4);
        for (int k = 1; k < 3; k++) begin
            stepCycles(2);
            done_with_note = 1'b1;
            waitEvent(1'b0, 20, "t1_strobe", w);
            done_with_note = 1'b0;
            checkOutput("t1_latency", 32'(w), 32'd4);
        end
        stepCycles(2);
        done_with_note = 1'b1;
        waitEvent(1'b1, 20, "t1_song_done", w);
        done_with_note = 1'b0;
        checkOutput("t1_done_latency", 32'(w), 32'd4);
        stepCycles(2);
        done_with_note = 1'b1;
        stepCycles(1);
        done_with_note = 1'b0;
        stepCycles(8);
        checkOutput("t1_strobes", 32'(strobe_count - s0), 32'd3);
        checkOutput("t1_done_pulses", 32'(done_count - d0), 32'd1);
        checkOutput("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Song 2 with done_with_note stuck high: ARM guard spaces strobes.
        $display("[TB] song 2 with done held high");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b1);
        stepCycles(2);
        pushSong(2);
        s0          = strobe_count;
        d0          = done_count;
        min_gap     = 1000;
        last_strobe = -1000;
        play        = 1'b1;
        waitEvent(1'b1, 60, "t2_song_done", w);
        stepCycles(2);
        checkOutput("t2_strobes", 32'(strobe_count - s0), 32'd3);
        checkOutput("t2_min_gap", 32'(min_gap), 32'd5);
        checkOutput("t2_done_pulses", 32'(done_count - d0), 32'd1);

        // Song 3: 32 entries, no end marker, index wraps.
        $display("[TB] full-length song 3");
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b1);
        stepCycles(2);
        pushSong(3);
        s0          = strobe_count;
        d0          = done_count;
        window_song = 2'd3;
        window_en   = 1'b1;
        play        = 1'b1;
        waitEvent(1'b1, 400, "t3_song_done", w);
        stepCycles(5);
        checkOutput("t3_strobes", 32'(strobe_count - s0), 32'd32);
        checkOutput("t3_done_pulses", 32'(done_count - d0), 32'd1);
        checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t3_addr_in_window", 32'(addr_bad), 32'd0);
        checkOutput("t3_parked_addr", 32'(rom_addr), 32'h7f);
        window_en = 1'b0;

        // Song 0: pause for 10 cycles in PLAYING with done high.
        $display("[TB] pause during song 0");
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        stepCycles(3);
        pushSong(0);
        play = 1'b1;
        waitEvent(1'b0, 20, "t4_first_strobe", w);
        stepCycles(2);
        play           = 1'b0;
        done_with_note = 1'b1;
        s0             = strobe_count;
        stepCycles(10);
        checkOutput("t4_pause_no_strobe", 32'(strobe_count - s0), 32'd0);
        checkOutput("t4_pause_rom_addr", 32'(rom_addr), 32'h00);
        play = 1'b1;
        waitEvent(1'b0, 20, "t4_resume_strobe", w);
        checkOutput("t4_resume_latency", 32'(w), 32'd4);
        waitEvent(1'b1, 20, "t4_song_done", w);
        checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Song switch 0 -> 2 while a note is playing.
        $display("[TB] song switch mid-song");
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        stepCycles(2);
        exp_q.push_back(mk(5, 3));
        play = 1'b1;
        waitEvent(1'b0, 20, "t5_first_strobe", w);
        stepCycles(2);
        d0   = done_count;
        song = 2'd2;
        stepCycles(2);
        checkOutput("t5_new_rom_addr", 32'(rom_addr), 32'h40);
        checkOutput("t5_no_done_on_switch", 32'(done_count - d0), 32'd0);
        window_song = 2'd2;
        window_en   = 1'b1;
        pushSong(2);
        s0             = strobe_count;
        done_with_note = 1'b1;
        waitEvent(1'b1, 60, "t5_song_done", w);
        stepCycles(2);
        checkOutput("t5_strobes", 32'(strobe_count - s0), 32'd3);
        checkOutput("t5_done_pulses", 32'(done_count - d0), 32'd1);
        checkOutput("t5_addr_in_window", 32'(addr_bad), 32'd0);
        window_en = 1'b0;

        // Reset while the ROM read is in flight.
        $display("[TB] reset during WAIT_ROM");
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b0);
        stepCycles(3);
        s0   = strobe_count;
        d0   = done_count;
        play = 1'b1;
        stepCycles(2);
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b0);
        stepCycles(1);
        checkOutput("t6_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("t6_note", 32'(note_to_load), 32'd0);
        checkOutput("t6_duration", 32'(duration_to_load), 32'd0);
        checkOutput("t6_load", 32'(load_new_note), 32'd0);
        reset = 1'b0;
        stepCycles(6);
        checkOutput("t6_no_strobe", 32'(strobe_count - s0), 32'd0);
        checkOutput("t6_no_done", 32'(done_count - d0), 32'd0);
`else
        // Looping build: two-note song 0 restarts without touching play.
        $display("[TB] repeat build, song 0 loops");
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        stepCycles(2);
        pushSong(0);
        exp_q.push_back(mk(5, 3));
        s0   = strobe_count;
        d0   = done_count;
        play = 1'b1;
        waitEvent(1'b1, 40, "r_song_done", w);
        waitEvent(1'b0, 20, "r_restart_strobe", w);
        checkOutput("r_restart_latency", 32'(w), 32'd3);
        play = 1'b0;
        stepCycles(4);
        checkOutput("r_strobes", 32'(strobe_count - s0), 32'd3);
        checkOutput("r_done_pulses", 32'(done_count - d0), 32'd1);
        checkOutput("r_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        stepCycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Upstream sequencer for note_player.
- Walks a song ROM entry by entry and presents {note, duration} with a one-cycle load_new_note strobe.
- Waits for done_with_note before fetching the next entry, and flags end of song.
- Sits between the top-level song/play controls and note_player.

Parameters:
- SONG_BITS, 2, log2 of the number of songs (4 songs).
- NOTE_ADDR_BITS, 5, log2 of entries per song (32 entries).
- ROM_ADDR_W, SONG_BITS+NOTE_ADDR_BITS, ROM address width (derived; do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play  input  1  1 = advance through song; 0 = pause
- song  input  SONG_BITS  selected song
- done_with_note  input  1  from note_player; high when current note's time is exhausted
- rom_addr  output  ROM_ADDR_W  {song_latched, entry_index}
- rom_data  input  12  {note[11:6], duration[5:0]}, valid 1 cycle after rom_addr (registered ROM)
- note_to_load  output  6  note code; 0 = rest
- duration_to_load  output  6  beats
- load_new_note  output  1  one-cycle strobe; note/duration valid in that cycle
- song_done  output  1  one-cycle pulse at end of song

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values:
  - all outputs 0; state IDLE; entry_index 0; song_latched 0.
  - Reset mid-song aborts with no strobe or pulse.
- FSM states: IDLE, FETCH, WAIT_ROM, LOAD, ARM, PLAYING, DONE.
- IDLE:
  - entry_index=0; song_latched<=song.
  - play=1 -> FETCH.
- FETCH: rom_addr driven with current index -> WAIT_ROM. Exactly 1 cycle.
- WAIT_ROM: rom_data captured into note/duration regs at end of cycle -> LOAD.
- LOAD:
  - If captured duration==0 (end marker): song_done=1 this cycle; load_new_note stays 0 -> DONE.
  - Else: load_new_note=1 -> ARM.
- ARM: one-cycle guard, ignores done_with_note (still high from the previous note) -> PLAYING.
- PLAYING: done_with_note=1 and play=1 -> increment entry_index, then:
  - if entry_index was max (2^NOTE_ADDR_BITS-1): song_done=1 next cycle -> DONE.
  - else -> FETCH.
- Pause: play=0 freezes the FSM in PLAYING. FETCH/WAIT_ROM/LOAD/ARM always complete, so a fetch in flight is still loaded.
- DONE: holds until play=0 or song!=song_latched -> IDLE.
- Song change: song!=song_latched in any state other than IDLE/DONE -> IDLE next cycle.
  - No load_new_note, no song_done.
  - Restart is from entry 0 of the new song.
- Latency: PLAYING with done_with_note=1 to load_new_note is 4 cycles (FETCH, WAIT_ROM, LOAD strobe).
- Outputs are registered.
- note_to_load/duration_to_load hold their last loaded values between strobes.
- rom_addr is stable except in FETCH/IDLE updates.
- Simultaneous reset with anything: reset wins.

Optional Feature:
- Macro SONG_READER_REPEAT_EN.
- Defined:
  - At end of song (marker or index wrap), pulse song_done, set entry_index=0 and go to FETCH (loops) instead of DONE.
  - Song change behaviour unchanged.
- Undefined: behaviour as above (stop in DONE).

Decomposition:
- Shared package (note_pkg):
  - NOTE_W=6, DUR_W=6, REST_NOTE=0, END_DURATION=0
  - FSM state encoding constants
  - ROM word field offsets
- One natural sub-module, song_rom: registered 12-bit ROM, 2^ROM_ADDR_W deep.
  - Instantiated at top level, not inside song_reader, so the bench can drive rom_data directly.

Test Plan:
- Song 1 = {(12,4),(20,2),(0,3),(x,0)}; play=1; done_with_note pulsed after each load.
  - -> three load_new_note strobes carrying 12/4, 20/2, 0/3, then one song_done pulse, FSM parks in DONE.
- done_with_note held constantly high.
  - -> ARM guard: exactly one strobe per PLAYING exit; no back-to-back loads.
  - -> strobe gap ≥4 cycles.
- Full 32-entry song with no zero-duration marker.
  - -> 32 strobes; song_done fires after index 31; rom_addr never leaves song's window.
- play dropped to 0 during PLAYING for 10 cycles while done_with_note=1.
  - -> no fetch while paused.
  - -> next strobe exactly 4 cycles after play returns to 1.
- song switched 0->2 mid-song.
  - -> no song_done; IDLE next cycle.
  - -> next rom_addr = {2'd2,5'd0} after play.
- Reset asserted during WAIT_ROM.
  - -> no strobe; outputs 0 next cycle.
- Repeat build (SONG_READER_REPEAT_EN): 2-note song.
  - -> song_done pulses, then first note strobes again without toggling play.
